fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: single-cycle instruction fetch with an IF/ID pipeline register.
//   The PC is a word address; imem_addr is the PC register itself, so instruction
//   memory answers within the same cycle. Each edge is resolved with priority
//   redirect > flush > stall > normal fetch.
// Optional feature: define FETCH_PERF_CNT_EN to add fetch_count/stall_count.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, flush               hold PC+IF/ID / squash IF/ID
//   redirect_valid/redirect_pc taken branch/jump and its word-address target
//   imem_addr / imem_instr     fetch address out, instruction back (combinational)
//   ifid_valid/pc/pc_next/instr IF/ID register contents (all registered)
//   fetch_count, stall_count   (FETCH_PERF_CNT_EN only) wrapping event counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int unsigned AW = 32,
  localparam int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_instr,
  output logic          ifid_valid,
  output logic [AW-1:0] ifid_pc,
  output logic [AW-1:0] ifid_pc_next,
  output logic [DW-1:0] ifid_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_FLUSH,
    ACT_STALL,
    ACT_FETCH
  } act_e;

  act_e          act;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic          valid_q, valid_d;
  logic [AW-1:0] ifpc_q, ifpc_d;
  logic [AW-1:0] ifpcn_q, ifpcn_d;
  logic [DW-1:0] instr_q, instr_d;

  // Per-edge action, highest priority first.
  always_comb begin
    act = ACT_FETCH;
    if (redirect_valid)  act = ACT_REDIRECT;
    else if (flush)      act = ACT_FLUSH;
    else if (stall)      act = ACT_STALL;
  end

  // Next PC and IF/ID contents.
  always_comb begin
    pc_inc  = pc_q + AW'(1);
    pc_d    = pc_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    ifpcn_d = ifpcn_q;
    instr_d = instr_q;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d    = redirect_pc;
        valid_d = 1'b0;
        ifpc_d  = '0;
        ifpcn_d = '0;
        instr_d = '0;
      end
      ACT_FLUSH: begin
        // Flush squashes IF/ID but the PC still obeys stall.
        pc_d    = stall ? pc_q : pc_inc;
        valid_d = 1'b0;
        ifpc_d  = '0;
        ifpcn_d = '0;
        instr_d = '0;
      end
      ACT_STALL: begin
      end
      ACT_FETCH: begin
        pc_d    = pc_inc;
        valid_d = 1'b1;
        ifpc_d  = pc_q;
        ifpcn_d = pc_inc;
        instr_d = imem_instr;
      end
      default: begin
      end
    endcase
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ifpc_q  <= '0;
      ifpcn_q <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      ifpcn_q <= ifpcn_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_pc      = ifpc_q;
  assign ifid_pc_next = ifpcn_q;
  assign ifid_instr   = instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;

  // Counters track normal fetches and pure stalls only.
  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (act == ACT_FETCH) fcnt_d = fcnt_q + 32'(1);
    if (act == ACT_STALL) scnt_d = scnt_q + 32'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif

endmodule
